m_wb_arbiter2: RTL and testbench

Two-master Wishbone classic arbiter sharing one slave port (the simple/dynamic wishbone register decode region) between the midgetv core (M0) and a second master (M1: loader/debug/DMA bench master).
- Round-robin grant, held for the whole CYC_I burst.
- Bus-timeout watchdog terminates stuck cycles so a slow or unmapped slave cannot hang the core.
- Sits between m_midgetv_core and the slave address decode in simulation tops and FPGA tops.

---
 rtl/m_wb_arbiter2_pkg.sv | 30 +++
 rtl/m_wb_arbiter2_if.sv | 16 +
 rtl/m_wb_tmo_watchdog.sv | 65 ++++++
 rtl/m_wb_arbiter2.sv | 124 ++++++++++++
 tb/tb_m_wb_arbiter2.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/m_wb_arbiter2_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state encoding
// (doubles as the one-hot grant value), owner identity and the request payload.
package m_wb_arbiter2_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned GNT_W = 2;

    // Encoding is chosen so the state register is directly the grant vector.
    typedef enum logic [GNT_W-1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } arb_state_e;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_e;

    // Master-to-slave payload travelling alongside CYC/STB.
    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/m_wb_arbiter2_if.sv
// Wishbone classic point-to-point link.
//   cyc, stb, req (we/sel/adr/dat) : master -> slave
//   dat_r, ack                     : slave  -> master
interface m_wb_arbiter2_if;
    import m_wb_arbiter2_pkg::*;

    logic             cyc;
    logic             stb;
    wb_req_t          req;
    logic [DAT_W-1:0] dat_r;
    logic             ack;

    modport master (output cyc, output stb, output req, input dat_r, input ack);
    modport slave  (input cyc, input stb, input req, output dat_r, output ack);

endinterface

// File: rtl/m_wb_tmo_watchdog.sv
// Bus-timeout watchdog: counts strobe cycles without acknowledge and forces
// a termination on the TIMEOUT-th one; keeps a sticky flag and a saturating
// event count.
//   clk, rst_n  : clock, async active-low reset
//   stb_raw     : strobe of the granted master before forced termination
//   ack         : slave acknowledge
//   tmo_clr     : clears tmo_flag / tmo_cnt (a simultaneous hit wins)
//   tmo_hit_c   : combinational, termination this cycle
//   tmo_flag    : sticky timeout seen
//   tmo_cnt     : saturating timeout count
module m_wb_tmo_watchdog #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stb_raw,
    input  logic            ack,
    input  logic            tmo_clr,
    output logic            tmo_hit_c,
    output logic            tmo_flag,
    output logic [CNTW-1:0] tmo_cnt
);

    localparam int unsigned      WCNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam bit               TMO_EN    = (TIMEOUT != 0);

    logic [WCNT_W-1:0] wcnt_q;
    logic              stb_o_c;

    // Slave ACK in the threshold cycle takes priority over the timeout.
    assign tmo_hit_c = TMO_EN && (wcnt_q == WCNT_LAST) && stb_raw && !ack;
    assign stb_o_c   = stb_raw & ~tmo_hit_c;

    // Wait counter: cleared whenever the visible strobe is low or acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else if (stb_o_c && !ack) begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
        end else begin
            wcnt_q <= '0;
        end
    end

    // Sticky flag and saturating count; a hit beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_flag <= 1'b0;
            tmo_cnt  <= '0;
        end else if (tmo_hit_c) begin
            tmo_flag <= 1'b1;
            if (tmo_clr) begin
                tmo_cnt <= CNTW'(1);
            end else if (!(&tmo_cnt)) begin
                tmo_cnt <= tmo_cnt + CNTW'(1);
            end
        end else if (tmo_clr) begin
            tmo_flag <= 1'b0;
            tmo_cnt  <= '0;
        end
    end

endmodule

// File: rtl/m_wb_arbiter2.sv
// Two-master Wishbone classic arbiter in front of one slave port.
// Round-robin grant held for a whole CYC burst, one idle cycle between
// owners, zero-latency mux once granted, bus-timeout watchdog.
//   CLK_I, RST_I : clock, async active-low reset
//   m0, m1       : master links (core, loader/debug/DMA)
//   s            : shared slave link
//   grant        : one-hot owner, 01 = M0, 10 = M1, 00 = idle
//   tmo_clr      : clears tmo_flag / tmo_cnt
//   tmo_flag     : sticky timeout seen
//   tmo_cnt      : saturating timeout count
module m_wb_arbiter2
    import m_wb_arbiter2_pkg::*;
#(
    parameter int unsigned TIMEOUT                  = 64,
    parameter bit          DAT_I_ZERO_WHEN_INACTIVE = 1'b1,
    parameter int unsigned CNTW                     = 8
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    m_wb_arbiter2_if.slave         m0,
    m_wb_arbiter2_if.slave         m1,
    m_wb_arbiter2_if.master        s,
    output logic [GNT_W-1:0]       grant,
    input  logic                   tmo_clr,
    output logic                   tmo_flag,
    output logic [CNTW-1:0]        tmo_cnt
);

    arb_state_e       state_q, state_d;
    mst_e             last_q, last_d;
    logic             stb_raw_c;
    logic             tmo_hit_c;
    logic [DAT_W-1:0] gnt_dat_c;
    logic [DAT_W-1:0] idle_dat_c;

    // Strobe of the current owner, gated by its CYC so a dropped cycle ends at once.
    assign stb_raw_c = (state_q == ST_G0) ? (m0.cyc & m0.stb) :
                       (state_q == ST_G1) ? (m1.cyc & m1.stb) : 1'b0;

    // Read data for the owner: zero on forced termination.
    assign gnt_dat_c = tmo_hit_c ? '0 :
                       (DAT_I_ZERO_WHEN_INACTIVE && !s.ack) ? '0 : s.dat_r;

    // Read data for a non-owner; held at zero through reset regardless of mode.
    assign idle_dat_c = (DAT_I_ZERO_WHEN_INACTIVE || !RST_I) ? '0 : s.dat_r;

    assign grant = GNT_W'(state_q);

    m_wb_tmo_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) u_wdog (
        .clk       (CLK_I),
        .rst_n     (RST_I),
        .stb_raw   (stb_raw_c),
        .ack       (s.ack),
        .tmo_clr   (tmo_clr),
        .tmo_hit_c (tmo_hit_c),
        .tmo_flag  (tmo_flag),
        .tmo_cnt   (tmo_cnt)
    );

    // State register; last starts at M1 so M0 wins the first tie.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            last_q  <= MST_M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state and bus mux.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.req    = '0;
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        m0.dat_r = idle_dat_c;
        m1.dat_r = idle_dat_c;

        unique case (state_q)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = (last_q == MST_M1) ? ST_G0 : ST_G1;
                end else if (m0.cyc) begin
                    state_d = ST_G0;
                end else if (m1.cyc) begin
                    state_d = ST_G1;
                end
            end
            ST_G0: begin
                s.cyc    = m0.cyc;
                s.stb    = stb_raw_c & ~tmo_hit_c;
                s.req    = m0.req;
                m0.ack   = s.ack | tmo_hit_c;
                m0.dat_r = gnt_dat_c;
                if (!m0.cyc) begin
                    state_d = ST_IDLE;
                    last_d  = MST_M0;
                end
            end
            ST_G1: begin
                s.cyc    = m1.cyc;
                s.stb    = stb_raw_c & ~tmo_hit_c;
                s.req    = m1.req;
                m1.ack   = s.ack | tmo_hit_c;
                m1.dat_r = gnt_dat_c;
                if (!m1.cyc) begin
                    state_d = ST_IDLE;
                    last_d  = MST_M1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_m_wb_arbiter2.sv
// Directed bench for the two-master Wishbone arbiter (TIMEOUT = 4).
module tb_m_wb_arbiter2;
    import m_wb_arbiter2_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tmo_clr;
    logic [1:0] grant;
    logic       tmo_flag;
    logic [7:0] tmo_cnt;

    int vectors;
    int miscompares;

    m_wb_arbiter2_if m0_bus ();
    m_wb_arbiter2_if m1_bus ();
    m_wb_arbiter2_if s_bus ();

    m_wb_arbiter2 #(
        .TIMEOUT                  (4),
        .DAT_I_ZERO_WHEN_INACTIVE (1'b1),
        .CNTW                     (8)
    ) dut (
        .CLK_I    (clk),
        .RST_I    (rst_n),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .s        (s_bus),
        .grant    (grant),
        .tmo_clr  (tmo_clr),
        .tmo_flag (tmo_flag),
        .tmo_cnt  (tmo_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        tmo_clr     = 1'b0;
        m0_bus.cyc  = 1'b0; m0_bus.stb = 1'b0; m0_bus.req = '0;
        m1_bus.cyc  = 1'b0; m1_bus.stb = 1'b0; m1_bus.req = '0;
        s_bus.dat_r = '0;   s_bus.ack  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        sample();
        chk("rst_grant", grant, 2'b00);
        chk("rst_cyc_o", s_bus.cyc, 1'b0);
        chk("rst_stb_o", s_bus.stb, 1'b0);
        chk("rst_m0_ack", m0_bus.ack, 1'b0);
        chk("rst_tmo_flag", tmo_flag, 1'b0);
        chk("rst_tmo_cnt", tmo_cnt, 8'h00);
        tick(); rst_n = 1'b1;

        // 1: M0 read of 0x6000_0004
        tick();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        m0_bus.req.we = 1'b0; m0_bus.req.sel = 4'hF; m0_bus.req.adr = 32'h6000_0004;
        s_bus.dat_r = 32'hDEAD_BEEF; s_bus.ack = 1'b0;
        sample();
        chk("t1_arb_latency_grant", grant, 2'b00);
        chk("t1_idle_cyc_o", s_bus.cyc, 1'b0);
        tick(); sample();
        chk("t1_grant_m0", grant, 2'b01);
        chk("t1_adr_o", s_bus.req.adr, 32'h6000_0004);
        chk("t1_stb_o", s_bus.stb, 1'b1);
        chk("t1_dat_zero_no_ack", m0_bus.dat_r, 32'h0);
        tick(); s_bus.ack = 1'b1; sample();
        chk("t1_m0_ack", m0_bus.ack, 1'b1);
        chk("t1_m0_dat", m0_bus.dat_r, 32'hDEAD_BEEF);
        chk("t1_m1_dat_zero", m1_bus.dat_r, 32'h0);
        chk("t1_m1_ack_zero", m1_bus.ack, 1'b0);
        tick(); m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; s_bus.ack = 1'b0; sample();
        chk("t1_cyc_o_follows_drop", s_bus.cyc, 1'b0);
        chk("t1_grant_held", grant, 2'b01);
        tick(); sample();
        chk("t1_back_idle", grant, 2'b00);

        // 2: tie after reset, M0 first, one idle cycle, then M1
        do_reset();
        tick(); m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1; sample();
        chk("t2_tie_idle", grant, 2'b00);
        tick(); sample();
        chk("t2_tie_m0_first", grant, 2'b01);
        tick(); m0_bus.cyc = 1'b0; sample();
        chk("t2_m0_drop_grant_held", grant, 2'b01);
        tick(); sample();
        chk("t2_idle_gap", grant, 2'b00);
        tick(); sample();
        chk("t2_grant_m1", grant, 2'b10);
        tick(); m1_bus.cyc = 1'b0; sample();
        tick(); m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1; sample();
        chk("t2_tie2_idle", grant, 2'b00);
        tick(); sample();
        chk("t2_tie2_m0", grant, 2'b01);
        tick(); m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0;
        tick();

        // 3: M1 burst of three acked transfers while M0 waits (last = M0)
        m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        m1_bus.req.we = 1'b1; m1_bus.req.sel = 4'h3;
        m1_bus.req.adr = 32'h6000_0010; m1_bus.req.dat = 32'h1111_2222;
        s_bus.ack = 1'b1; s_bus.dat_r = 32'h1234_5678;
        sample();
        chk("t3_idle_grant", grant, 2'b00);
        chk("t3_idle_ack_dropped", m1_bus.ack, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); sample();
            chk("t3_burst_grant", grant, 2'b10);
            chk("t3_burst_m1_ack", m1_bus.ack, 1'b1);
            chk("t3_burst_m1_dat", m1_bus.dat_r, 32'h1234_5678);
            chk("t3_burst_dat_o", s_bus.req.dat, 32'h1111_2222);
            chk("t3_burst_m0_ack", m0_bus.ack, 1'b0);
            chk("t3_burst_m0_dat", m0_bus.dat_r, 32'h0);
        end
        tick(); m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; s_bus.ack = 1'b0; sample();
        chk("t3_drop_grant_held", grant, 2'b10);
        tick(); sample();
        chk("t3_idle_gap", grant, 2'b00);
        tick(); sample();
        chk("t3_grant_m0", grant, 2'b01);
        tick(); m0_bus.cyc = 1'b0;
        tick();

        // 4: M0 write, slave never acks, watchdog terminates the 4th STB cycle
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.req.we = 1'b1;
        m0_bus.req.adr = 32'h6000_0008; m0_bus.req.dat = 32'hCAFE_F00D;
        s_bus.dat_r = 32'hAAAA_5555; s_bus.ack = 1'b0;
        sample();
        chk("t4_idle_grant", grant, 2'b00);
        tick(); sample();
        chk("t4_stb1_we_o", s_bus.req.we, 1'b1);
        chk("t4_stb1_dat_o", s_bus.req.dat, 32'hCAFE_F00D);
        chk("t4_stb1_ack", m0_bus.ack, 1'b0);
        tick(); tick(); sample();
        chk("t4_stb3_ack", m0_bus.ack, 1'b0);
        chk("t4_stb3_stb_o", s_bus.stb, 1'b1);
        tick(); sample();
        chk("t4_tmo_ack", m0_bus.ack, 1'b1);
        chk("t4_tmo_dat_zero", m0_bus.dat_r, 32'h0);
        chk("t4_tmo_stb_o_low", s_bus.stb, 1'b0);
        chk("t4_tmo_cyc_o", s_bus.cyc, 1'b1);
        chk("t4_flag_not_yet", tmo_flag, 1'b0);
        tick(); m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; sample();
        chk("t4_tmo_flag", tmo_flag, 1'b1);
        chk("t4_tmo_cnt", tmo_cnt, 8'h01);
        tick(); tmo_clr = 1'b1; sample();
        chk("t4_flag_before_clr", tmo_flag, 1'b1);
        tick(); tmo_clr = 1'b0; sample();
        chk("t4_clr_flag", tmo_flag, 1'b0);
        chk("t4_clr_cnt", tmo_cnt, 8'h00);

        // 5a: ACK exactly in the threshold cycle wins
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.req.we = 1'b0;
        s_bus.ack = 1'b0; s_bus.dat_r = 32'h0BAD_F00D;
        tick(); tick(); tick();
        tick(); s_bus.ack = 1'b1; sample();
        chk("t5_thr_ack", m0_bus.ack, 1'b1);
        chk("t5_thr_dat", m0_bus.dat_r, 32'h0BAD_F00D);
        chk("t5_thr_stb_o", s_bus.stb, 1'b1);
        tick(); m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; s_bus.ack = 1'b0; sample();
        chk("t5_thr_cnt", tmo_cnt, 8'h00);
        chk("t5_thr_flag", tmo_flag, 1'b0);
        tick();

        // 5b: continuous timeouts, one every 4 cycles, count saturates
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        repeat (1017) tick();
        sample();
        chk("t5_cnt_254", tmo_cnt, 8'hFE);
        repeat (4) tick();
        sample();
        chk("t5_cnt_255", tmo_cnt, 8'hFF);
        repeat (4) tick();
        sample();
        chk("t5_cnt_sat_256", tmo_cnt, 8'hFF);
        repeat (3) tick();
        tmo_clr = 1'b1; sample();
        chk("t5_hit_with_clr_ack", m0_bus.ack, 1'b1);
        tick(); tmo_clr = 1'b0; m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; sample();
        chk("t5_hit_beats_clr_cnt", tmo_cnt, 8'h01);
        chk("t5_hit_beats_clr_flag", tmo_flag, 1'b1);
        tick(); tmo_clr = 1'b1;
        tick(); tmo_clr = 1'b0; sample();
        chk("t5_final_clr_cnt", tmo_cnt, 8'h00);

        // 6: asynchronous reset while M1 holds STB
        tick(); m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; s_bus.ack = 1'b0; sample();
        chk("t6_idle_grant", grant, 2'b00);
        tick(); sample();
        chk("t6_grant_m1", grant, 2'b10);
        chk("t6_stb_o_high", s_bus.stb, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_cyc_o", s_bus.cyc, 1'b0);
        chk("t6_async_stb_o", s_bus.stb, 1'b0);
        chk("t6_async_grant", grant, 2'b00);
        chk("t6_async_m1_ack", m1_bus.ack, 1'b0);
        tick(); tick();
        m0_bus.cyc = 1'b1; rst_n = 1'b1; sample();
        chk("t6_post_rst_idle", grant, 2'b00);
        tick(); sample();
        chk("t6_tie_after_reset_m0", grant, 2'b01);

        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
